// File: rtl/maxp_array.sv
// Multi-lane windowed max-pooling unit: per-lane running maximum over win_len beats,
// one write of the packed maxima per completed window.
module maxp_array #(
    parameter int unsigned DATA_SIZE = 16,
    parameter int unsigned MEM_SIZE  = 10,
    parameter int unsigned LANES     = 4,
    parameter int unsigned CNT_W     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       in_valid,
    input  logic [MEM_SIZE-1:0]        in_wa,
    input  logic [LANES*DATA_SIZE-1:0] in_data,
    input  logic [CNT_W-1:0]           win_len,
    input  logic                       signed_mode,
    input  logic                       relu_en,
    output logic                       out_we,
    output logic [MEM_SIZE-1:0]        out_wa,
    output logic [LANES*DATA_SIZE-1:0] out_wd,
    output logic                       busy
);

    localparam int unsigned W = LANES * DATA_SIZE;

    // Stage 1 input registers
    logic                en_q;
    logic                valid_q;
    logic [MEM_SIZE-1:0] wa_q;
    logic [W-1:0]        data_q;
    logic [CNT_W-1:0]    len_q;
    logic                sgn_q;
    logic                relu_q;

    // Stage 2 window state
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0] lat_len_q, lat_len_d;
    logic             lat_sgn_q, lat_sgn_d;
    logic             lat_relu_q, lat_relu_d;

    logic                out_we_d;
    logic [MEM_SIZE-1:0] out_wa_d;
    logic [W-1:0]        out_wd_d;

    logic             first_beat;
    logic [CNT_W-1:0] eff_len_raw;
    logic [CNT_W:0]   eff_len;
    logic [CNT_W:0]   cnt_inc;
    logic             eff_sgn;
    logic             eff_relu;
    logic             last_beat;
    logic [W-1:0]     acc_new;
    logic [W-1:0]     res_vec;

    // Config comes straight from stage 1 on the first beat, from the latch afterwards.
    assign first_beat  = (cnt_q == '0);
    assign eff_len_raw = first_beat ? len_q : lat_len_q;
    assign eff_len     = (eff_len_raw == '0) ? (CNT_W+1)'(1) : {1'b0, eff_len_raw};
    assign eff_sgn     = first_beat ? sgn_q : lat_sgn_q;
    assign eff_relu    = first_beat ? relu_q : lat_relu_q;
    assign cnt_inc     = {1'b0, cnt_q} + (CNT_W+1)'(1);
    assign last_beat   = (cnt_inc == eff_len);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [DATA_SIZE-1:0] smp;
        logic [DATA_SIZE-1:0] cur;
        logic [DATA_SIZE-1:0] nxt;
        logic                 gt;

        assign smp = data_q[g*DATA_SIZE +: DATA_SIZE];
        assign cur = acc_q[g*DATA_SIZE +: DATA_SIZE];
        // Direct magnitude compare; no subtraction so extremes never wrap.
        assign gt  = eff_sgn ? ($signed(smp) > $signed(cur)) : (smp > cur);
        assign nxt = (first_beat || gt) ? smp : cur;

        assign acc_new[g*DATA_SIZE +: DATA_SIZE] = nxt;
        assign res_vec[g*DATA_SIZE +: DATA_SIZE] =
            (eff_sgn && eff_relu && nxt[DATA_SIZE-1]) ? '0 : nxt;
    end

    always_comb begin
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        lat_len_d  = lat_len_q;
        lat_sgn_d  = lat_sgn_q;
        lat_relu_d = lat_relu_q;
        out_we_d   = 1'b0;
        out_wa_d   = out_wa;
        out_wd_d   = out_wd;

        if (!en_q) begin
            cnt_d = '0;
            acc_d = '0;
        end else if (valid_q) begin
            acc_d = acc_new;
            if (first_beat) begin
                lat_len_d  = len_q;
                lat_sgn_d  = sgn_q;
                lat_relu_d = relu_q;
            end
            if (last_beat) begin
                cnt_d    = '0;
                out_we_d = 1'b1;
                out_wa_d = wa_q;
                out_wd_d = res_vec;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q       <= 1'b0;
            valid_q    <= 1'b0;
            wa_q       <= '0;
            data_q     <= '0;
            len_q      <= '0;
            sgn_q      <= 1'b0;
            relu_q     <= 1'b0;
            cnt_q      <= '0;
            acc_q      <= '0;
            lat_len_q  <= '0;
            lat_sgn_q  <= 1'b0;
            lat_relu_q <= 1'b0;
            out_we     <= 1'b0;
            out_wa     <= '0;
            out_wd     <= '0;
        end else begin
            en_q       <= en;
            valid_q    <= in_valid;
            wa_q       <= in_wa;
            data_q     <= in_data;
            len_q      <= win_len;
            sgn_q      <= signed_mode;
            relu_q     <= relu_en;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            lat_len_q  <= lat_len_d;
            lat_sgn_q  <= lat_sgn_d;
            lat_relu_q <= lat_relu_d;
            out_we     <= out_we_d;
            out_wa     <= out_wa_d;
            out_wd     <= out_wd_d;
        end
    end

    assign busy = (cnt_q != '0);

endmodule

// File: tb/tb_maxp_array.sv
// Bench for maxp_array: directed scenarios plus randomized windows against a max/ReLU model.
module tb_maxp_array;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        in_valid;
    logic [9:0]  in_wa;
    logic [31:0] in_data;
    logic [3:0]  win_len;
    logic        signed_mode;
    logic        relu_en;
    logic        out_we;
    logic [9:0]  out_wa;
    logic [31:0] out_wd;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int beat_cyc = 0;

    logic [9:0]  cap_wa[$];
    logic [31:0] cap_wd[$];
    int          cap_cyc[$];
    logic [9:0]  exp_wa[$];
    logic [31:0] exp_wd[$];
    logic [31:0] win_beats[$];

    maxp_array #(
        .DATA_SIZE(16),
        .MEM_SIZE (10),
        .LANES    (2),
        .CNT_W    (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .in_valid   (in_valid),
        .in_wa      (in_wa),
        .in_data    (in_data),
        .win_len    (win_len),
        .signed_mode(signed_mode),
        .relu_en    (relu_en),
        .out_we     (out_we),
        .out_wa     (out_wa),
        .out_wd     (out_wd),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_we === 1'b1) begin
            cap_wa.push_back(out_wa);
            cap_wd.push_back(out_wd);
            cap_cyc.push_back(cyc);
        end
    end

    // Reference: plain integer maximum over the window's beats, ReLU applied to the result.
    function automatic logic [31:0] model(input logic sgn, input logic relu);
        logic [31:0] res;
        logic [15:0] s;
        int          v;
        int          best;
        logic [31:0] tmp;
        res  = '0;
        best = 0;
        for (int l = 0; l < 2; l++) begin
            for (int k = 0; k < win_beats.size(); k++) begin
                s = win_beats[k][l*16 +: 16];
                if (sgn) v = $signed(s);
                else     v = int'({16'b0, s});
                if (k == 0 || v > best) best = v;
            end
            if (sgn && relu && best < 0) best = 0;
            tmp = best;
            res[l*16 +: 16] = tmp[15:0];
        end
        return res;
    endfunction

    function automatic logic [15:0] rnd_sample();
        case ($urandom_range(0, 5))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            2:       return 16'h0000;
            3:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic clear_all();
        cap_wa.delete();
        cap_wd.delete();
        cap_cyc.delete();
        exp_wa.delete();
        exp_wd.delete();
        win_beats.delete();
    endtask

    task automatic beat(input logic [9:0] wa, input logic [31:0] d, input logic [3:0] len,
                        input logic sgn, input logic relu);
        in_valid    = 1'b1;
        in_wa       = wa;
        in_data     = d;
        win_len     = len;
        signed_mode = sgn;
        relu_en     = relu;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = $urandom;
        in_wa    = 10'($urandom);
        beat_cyc = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; in_valid = 1'b0; in_wa = '0; in_data = '0;
        win_len = '0; signed_mode = 1'b0; relu_en = 1'b0;
        idle(3);
        checks += 4;
        if (out_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", out_we); end
        if (out_wa !== '0) begin failures++; $display("FAIL reset_wa got=%h exp=0", out_wa); end
        if (out_wd !== '0) begin failures++; $display("FAIL reset_wd got=%h exp=0", out_wd); end
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst = 1'b0;
        en  = 1'b1;
        idle(2);
    endtask

    task automatic test_basic();
        logic [15:0] l0[4];
        logic [31:0] d;
        logic [31:0] exp;
        l0[0] = 16'd3; l0[1] = 16'hFFFB; l0[2] = 16'd9; l0[3] = 16'd2;
        clear_all();
        for (int k = 0; k < 4; k++) begin
            d = {rnd_sample(), l0[k]};
            win_beats.push_back(d);
            beat(10'h10 + 10'(k), d, 4'd4, 1'b1, 1'b0);
            if (k == 0) begin
                checks++;
                if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_b1 got=%b exp=0", busy); end
            end else if (k == 1) begin
                checks++;
                if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_b2 got=%b exp=1", busy); end
            end
        end
        exp = model(1'b1, 1'b0);
        idle(2);
        checks += 2;
        if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_end got=%b exp=0", busy); end
        if (cap_wa.size() != 1) begin
            failures++;
            $display("FAIL basic_count got=%0d exp=1", cap_wa.size());
        end else begin
            checks += 4;
            if (cap_wa[0] !== 10'h13) begin failures++; $display("FAIL basic_wa got=%h exp=013", cap_wa[0]); end
            if (cap_wd[0][15:0] !== 16'd9) begin
                failures++; $display("FAIL basic_lane0 got=%h exp=0009", cap_wd[0][15:0]);
            end
            if (cap_wd[0] !== exp) begin failures++; $display("FAIL basic_wd got=%h exp=%h", cap_wd[0], exp); end
            if (cap_cyc[0] != beat_cyc + 1) begin
                failures++; $display("FAIL basic_latency got=%0d exp=%0d", cap_cyc[0], beat_cyc + 1);
            end
        end
    endtask

    task automatic test_signed_unsigned();
        logic [31:0] exp;
        for (int m = 0; m < 2; m++) begin
            clear_all();
            beat(10'h20, {16'h8000, 16'h7FFF}, 4'd2, m[0], 1'b0);
            beat(10'h21, {16'h7FFF, 16'h8000}, 4'd2, m[0], 1'b0);
            idle(2);
            exp = m[0] ? 32'h7FFF_7FFF : 32'h8000_8000;
            checks++;
            if (cap_wd.size() != 1 || cap_wd[0] !== exp) begin
                failures++;
                $display("FAIL sign_mode%0d got=%h (n=%0d) exp=%h", m,
                         cap_wd.size() > 0 ? cap_wd[0] : 32'hx, cap_wd.size(), exp);
            end
        end
    endtask

    task automatic test_relu();
        logic [15:0] l1[3];
        logic [31:0] d;
        logic [31:0] exp;
        l1[0] = 16'hFFF9; l1[1] = 16'hFFFE; l1[2] = 16'hFFF7;
        for (int r = 1; r >= 0; r--) begin
            clear_all();
            for (int k = 0; k < 3; k++) begin
                d = {l1[k], rnd_sample()};
                win_beats.push_back(d);
                beat(10'h30 + 10'(k), d, 4'd3, 1'b1, r[0]);
            end
            exp = model(1'b1, r[0]);
            idle(2);
            checks += 2;
            if (cap_wd.size() != 1) begin
                failures++; $display("FAIL relu%0d_count got=%0d exp=1", r, cap_wd.size());
            end else begin
                if (cap_wd[0][31:16] !== (r[0] ? 16'h0000 : 16'hFFFE)) begin
                    failures++;
                    $display("FAIL relu%0d_lane1 got=%h exp=%h", r, cap_wd[0][31:16],
                             r[0] ? 16'h0000 : 16'hFFFE);
                end
                if (cap_wd[0] !== exp) begin
                    failures++; $display("FAIL relu%0d_wd got=%h exp=%h", r, cap_wd[0], exp);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_all();
        for (int k = 1; k <= 5; k++) beat(10'h40 + 10'(k), {16'(k), 16'(k)}, 4'd1, 1'b0, 1'b0);
        idle(3);
        checks++;
        if (cap_wd.size() != 5) begin
            failures++; $display("FAIL b2b_count got=%0d exp=5", cap_wd.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks += 3;
                if (cap_wd[k] !== {16'(k + 1), 16'(k + 1)}) begin
                    failures++; $display("FAIL b2b_wd%0d got=%h exp=%0d", k, cap_wd[k], k + 1);
                end
                if (cap_wa[k] !== 10'h41 + 10'(k)) begin
                    failures++; $display("FAIL b2b_wa%0d got=%h exp=%h", k, cap_wa[k], 10'h41 + 10'(k));
                end
                if (cap_cyc[k] != cap_cyc[0] + k) begin
                    failures++; $display("FAIL b2b_gap%0d got=%0d exp=%0d", k, cap_cyc[k], cap_cyc[0] + k);
                end
            end
        end
    endtask

    task automatic test_abort();
        clear_all();
        beat(10'h50, 32'h7000_7000, 4'd4, 1'b0, 1'b0);
        beat(10'h51, 32'h6000_6000, 4'd4, 1'b0, 1'b0);
        en = 1'b0;
        idle(1);
        en = 1'b1;
        for (int k = 0; k < 4; k++) beat(10'h52 + 10'(k), 32'h0001_0001, 4'd4, 1'b0, 1'b0);
        idle(3);
        checks++;
        if (cap_wd.size() != 1 || cap_wd[0] !== 32'h0001_0001 || cap_wa[0] !== 10'h55) begin
            failures++;
            $display("FAIL abort got_n=%0d wd=%h wa=%h exp n=1 wd=00010001 wa=055", cap_wd.size(),
                     cap_wd.size() > 0 ? cap_wd[0] : 32'hx, cap_wa.size() > 0 ? cap_wa[0] : 10'hx);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic [31:0] exp;
        clear_all();
        for (int k = 0; k < 3; k++) beat(10'h60 + 10'(k), 32'h7FFF_7FFF, 4'd4, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        checks += 4;
        if (out_we !== 1'b0) begin failures++; $display("FAIL rstmid_we got=%b exp=0", out_we); end
        if (out_wa !== '0) begin failures++; $display("FAIL rstmid_wa got=%h exp=0", out_wa); end
        if (out_wd !== '0) begin failures++; $display("FAIL rstmid_wd got=%h exp=0", out_wd); end
        if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            d = {rnd_sample(), rnd_sample()};
            win_beats.push_back(d);
            beat(10'h70 + 10'(k), d, 4'd4, 1'b1, 1'b0);
        end
        exp = model(1'b1, 1'b0);
        idle(3);
        checks++;
        if (cap_wd.size() != 1 || cap_wd[0] !== exp || cap_wa[0] !== 10'h73) begin
            failures++;
            $display("FAIL rstmid_window got_n=%0d wd=%h exp n=1 wd=%h", cap_wd.size(),
                     cap_wd.size() > 0 ? cap_wd[0] : 32'hx, exp);
        end
    endtask

    task automatic test_random();
        logic [3:0]  len;
        int          eff;
        logic        sgn;
        logic        relu;
        logic [9:0]  wa;
        logic [31:0] d;
        int          n;
        clear_all();
        for (int w = 0; w < 40; w++) begin
            len  = 4'($urandom_range(0, 5));
            eff  = (len == 0) ? 1 : int'(len);
            sgn  = 1'($urandom);
            relu = 1'($urandom);
            win_beats.delete();
            for (int b = 0; b < eff; b++) begin
                d  = {rnd_sample(), rnd_sample()};
                wa = 10'($urandom);
                win_beats.push_back(d);
                // Later beats carry scrambled config, which must be ignored.
                if (b == 0) beat(wa, d, len, sgn, relu);
                else        beat(wa, d, 4'($urandom), 1'($urandom), 1'($urandom));
                if (b == eff - 1) exp_wa.push_back(wa);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
            exp_wd.push_back(model(sgn, relu));
            if ($urandom_range(0, 1) == 0) idle($urandom_range(0, 2));
        end
        idle(3);
        checks++;
        if (cap_wd.size() != exp_wd.size()) begin
            failures++;
            $display("FAIL rand_count got=%0d exp=%0d", cap_wd.size(), exp_wd.size());
        end
        n = (cap_wd.size() < exp_wd.size()) ? cap_wd.size() : exp_wd.size();
        for (int k = 0; k < n; k++) begin
            checks += 2;
            if (cap_wd[k] !== exp_wd[k]) begin
                failures++; $display("FAIL rand_wd%0d got=%h exp=%h", k, cap_wd[k], exp_wd[k]);
            end
            if (cap_wa[k] !== exp_wa[k]) begin
                failures++; $display("FAIL rand_wa%0d got=%h exp=%h", k, cap_wa[k], exp_wa[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed_unsigned();
        test_relu();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/maxp_array.md
Name: maxp_array

Overview:
- Multi-lane, window-based max-pooling unit for the CNN datapath; next generation of the single-lane running-max pool block.
- Accepts LANES parallel samples per beat and tracks a per-lane maximum over a programmable window of win_len beats.
- Emits one write (enable, address, packed max vector) per completed window to the downstream feature-map memory.
- Adds over the previous generation: parametrised lanes, windowed counting, signed/unsigned mode, optional ReLU clamp, overflow-safe compare, and abort.

Parameters:
- DATA_SIZE, 16, bit width of one lane sample.
- MEM_SIZE, 10, write-address width.
- LANES, 4, number of parallel lanes (≥1).
- CNT_W, 4, width of the window-length field and beat counter.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- en  input  1  unit enable; low aborts the window in progress and clears state
- in_valid  input  1  beat valid; one sample per lane is taken when high
- in_wa  input  MEM_SIZE  destination address carried with the beat
- in_data  input  LANES*DATA_SIZE  packed samples, lane i at [i*DATA_SIZE +: DATA_SIZE]
- win_len  input  CNT_W  beats per window; value 0 is treated as 1
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned compare
- relu_en  input  1  1 = clamp negative results to 0 on output (signed_mode only)
- out_we  output  1  one-cycle write strobe per completed window
- out_wa  output  MEM_SIZE  address of the window's last beat
- out_wd  output  LANES*DATA_SIZE  packed per-lane maxima
- busy  output  1  high while a window is partially accumulated

Behaviour:
- Reset (async, rst=1): out_we=0, out_wa=0, out_wd=0, busy=0, beat counter=0, accumulators=0, stage-1 registers=0. Takes effect immediately, including mid-window; the partial window is discarded and nothing is written.
- Stage 1: registers en, in_valid, in_wa, in_data, win_len, signed_mode and relu_en every cycle.
- Config sampling: win_len, signed_mode and relu_en are latched on the first beat of a window. Changes mid-window have no effect until the next window.
- Stage 2 accumulate, on a registered valid beat with registered en=1:
  - counter==0: accumulator[i] loads the sample directly.
  - otherwise: accumulator[i] takes the sample if it is greater than accumulator[i] (strictly greater; ties keep the old value).
  - The comparison is a true magnitude compare per signed_mode. No subtract-and-sign-bit, so there is no wrap error at the extremes: 0x7FFF vs 0x8000 resolves correctly in both modes.
- Counter: increments on each accumulated beat. When counter+1 == latched win_len (effective, ≥1), the window completes:
  - counter returns to 0.
  - Next cycle: out_we=1, out_wa = that beat's address, out_wd = final maxima, including the current beat's contribution.
- ReLU: applied only on output. When signed_mode=1 and relu_en=1, lanes with MSB set output 0. Ignored when signed_mode=0.
- Latency: 2 cycles from the last in_valid beat of a window to out_we high. Back-to-back windows are supported at full rate with no bubble. win_len=1 gives one output per beat.
- out_we: high for exactly one cycle per window. out_wa and out_wd hold their last values while out_we=0.
- Registered en=0:
  - counter=0 and accumulators=0.
  - A window that would complete in this cycle is discarded.
  - out_we=0; out_wd is not changed.
  - in_valid is ignored.
- Beats with in_valid=0 do not advance the counter; gaps within a window are allowed.
- busy = (counter != 0).

Test Plan:
- DATA_SIZE=16, LANES=2, signed, win_len=4; lane0 beats 3, -5, 9, 2 at wa 0x10..0x13 -> 2 cycles after the 4th beat, out_we=1, out_wa=0x13, lane0=9; busy high only during beats 2–4.
- Signed vs unsigned: lane0 beats 0x7FFF, 0x8000 with win_len=2 -> signed result 0x7FFF, unsigned result 0x8000.
- ReLU: signed, relu_en=1, win_len=3, lane1 beats -7, -2, -9 -> out lane1=0x0000; same stimulus with relu_en=0 -> 0xFFFE.
- Back-to-back: win_len=1, 5 consecutive beats values 1..5 -> 5 consecutive out_we pulses with out_wd 1..5, no gaps.
- Abort: win_len=4, 2 beats, then en=0 for 1 cycle, then 4 beats of 1, 1, 1, 1 -> exactly one out_we, out_wd=1 per lane; the pre-abort maxima do not appear in the output.
- Reset mid-window: assert rst after 3 of 4 beats -> all outputs 0 immediately and busy=0; the following full window is correct, with no write from the aborted window.
